// File: rtl/proc_ctrl.sv
// ============================================================================
// proc_ctrl : T0..T3 control sequencer for a simple 9-bit bus processor
// Rev 1.0
// ============================================================================
`default_nettype none

module proc_ctrl (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       Run,
   input  logic [8:0] DIN,
   output logic       IRin,
   output logic [7:0] Rin,
   output logic [7:0] Rout,
   output logic       Ain,
   output logic       Gin,
   output logic       Gout,
   output logic       DINout,
   output logic       AddSub,
   output logic       Done,
   output logic       Err,
   output logic       Busy
);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [8:0] r_ir;
   logic [2:0] w_op;
   logic [7:0] w_x_oh;
   logic [7:0] w_y_oh;

   assign w_op   = r_ir[8:6];
   assign w_x_oh = 8'd1 << r_ir[5:3];
   assign w_y_oh = 8'd1 << r_ir[2:0];

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state <= T0;
         r_ir    <= 9'h000;
      end else begin
         r_state <= w_next;
         if (r_state == T0 && Run) begin
            r_ir <= DIN;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      IRin   = 1'b0;
      Rin    = 8'h00;
      Rout   = 8'h00;
      Ain    = 1'b0;
      Gin    = 1'b0;
      Gout   = 1'b0;
      DINout = 1'b0;
      AddSub = 1'b0;
      Done   = 1'b0;
      Err    = 1'b0;
      Busy   = (r_state != T0);

      case (r_state)
         T0: begin
            IRin = Run;
            if (Run) begin
               w_next = T1;
            end
         end
         T1: begin
            case (w_op)
               3'b000: begin
                  Rout   = w_y_oh;
                  Rin    = w_x_oh;
                  Done   = 1'b1;
                  w_next = T0;
               end
               3'b001: begin
                  DINout = 1'b1;
                  Rin    = w_x_oh;
                  Done   = 1'b1;
                  w_next = T0;
               end
               3'b010, 3'b011: begin
                  Rout   = w_x_oh;
                  Ain    = 1'b1;
                  w_next = T2;
               end
               default: begin
                  Done   = 1'b1;
                  Err    = 1'b1;
                  w_next = T0;
               end
            endcase
         end
         T2: begin
            Rout   = w_y_oh;
            Gin    = 1'b1;
            AddSub = r_ir[6];
            w_next = T3;
         end
         T3: begin
            Gout   = 1'b1;
            Rin    = w_x_oh;
            Done   = 1'b1;
            w_next = T0;
         end
      endcase

      // Reset must silence every output at once, IRin included even with Run high.
      if (!Resetn) begin
         IRin   = 1'b0;
         Rin    = 8'h00;
         Rout   = 8'h00;
         Ain    = 1'b0;
         Gin    = 1'b0;
         Gout   = 1'b0;
         DINout = 1'b0;
         AddSub = 1'b0;
         Done   = 1'b0;
         Err    = 1'b0;
         Busy   = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_proc_ctrl.sv
// ============================================================================
// tb_proc_ctrl : directed self-checking bench for proc_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_proc_ctrl;

   logic       Clock;
   logic       Resetn;
   logic       Run;
   logic [8:0] DIN;
   logic       IRin;
   logic [7:0] Rin;
   logic [7:0] Rout;
   logic       Ain;
   logic       Gin;
   logic       Gout;
   logic       DINout;
   logic       AddSub;
   logic       Done;
   logic       Err;
   logic       Busy;

   int checks = 0;
   int errors = 0;

   logic [24:0] w_obs;
   logic [24:0] exp_v;

   proc_ctrl dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .Run    (Run),
      .DIN    (DIN),
      .IRin   (IRin),
      .Rin    (Rin),
      .Rout   (Rout),
      .Ain    (Ain),
      .Gin    (Gin),
      .Gout   (Gout),
      .DINout (DINout),
      .AddSub (AddSub),
      .Done   (Done),
      .Err    (Err),
      .Busy   (Busy)
   );

   assign w_obs = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Err, Busy};

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Expected output vector, laid out in the same order as w_obs.
   function automatic logic [24:0] pack(
      input logic       irin,
      input logic [7:0] rin,
      input logic [7:0] rout,
      input logic       ain,
      input logic       gin,
      input logic       gout,
      input logic       dinout,
      input logic       addsub,
      input logic       done,
      input logic       err,
      input logic       busy);
      return {irin, rin, rout, ain, gin, gout, dinout, addsub, done, err, busy};
   endfunction

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Resetn = 1'b0; Run = 1'b1; DIN = 9'h1FF;
      #2;
      exp_v = pack(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL reset_run_high obs=%h exp=%h", w_obs, exp_v);
      end
      step();
      Run = 1'b0;
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL reset_held obs=%h exp=%h", w_obs, exp_v);
      end
      Resetn = 1'b1;
      #1;
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL reset_release obs=%h exp=%h", w_obs, exp_v);
      end
      step();
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL idle_after_release obs=%h exp=%h", w_obs, exp_v);
      end
   endtask

   task automatic test_mvi();
      Run = 1'b1; DIN = 9'b001_011_000;
      #1;
      exp_v = pack(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL mvi_t0 obs=%h exp=%h", w_obs, exp_v);
      end
      step();
      Run = 1'b0; DIN = 9'h05A;
      #1;
      exp_v = pack(0, 8'h08, 8'h00, 0, 0, 0, 1, 0, 1, 0, 1);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL mvi_t1 obs=%h exp=%h", w_obs, exp_v);
      end
      step();
      exp_v = pack(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL mvi_after obs=%h exp=%h", w_obs, exp_v);
      end
   endtask

   task automatic test_mv();
      Run = 1'b1; DIN = 9'b000_101_011;
      step();
      Run = 1'b0; DIN = 9'h000;
      #1;
      exp_v = pack(0, 8'h20, 8'h08, 0, 0, 0, 0, 0, 1, 0, 1);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL mv_t1 obs=%h exp=%h", w_obs, exp_v);
      end
      step();
      // mv R3,R3: X equal to Y is sequenced like any other move
      Run = 1'b1; DIN = 9'b000_011_011;
      step();
      Run = 1'b0;
      #1;
      exp_v = pack(0, 8'h08, 8'h08, 0, 0, 0, 0, 0, 1, 0, 1);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL mv_same_t1 obs=%h exp=%h", w_obs, exp_v);
      end
      step();
   endtask

   task automatic test_sub();
      Run = 1'b1; DIN = 9'b011_001_010;
      step();
      Run = 1'b1; DIN = 9'b001_111_000;
      #1;
      exp_v = pack(0, 8'h00, 8'h02, 1, 0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL sub_t1 obs=%h exp=%h", w_obs, exp_v);
      end
      step();
      exp_v = pack(0, 8'h00, 8'h04, 0, 1, 0, 0, 1, 0, 0, 1);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL sub_t2 obs=%h exp=%h", w_obs, exp_v);
      end
      step();
      Run = 1'b0;
      #1;
      exp_v = pack(0, 8'h02, 8'h00, 0, 0, 1, 0, 0, 1, 0, 1);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL sub_t3 obs=%h exp=%h", w_obs, exp_v);
      end
      step();
      exp_v = pack(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL sub_after obs=%h exp=%h", w_obs, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      Run = 1'b1; DIN = 9'b010_000_000;
      step();
      DIN = 9'b000_110_001;
      #1;
      exp_v = pack(0, 8'h00, 8'h01, 1, 0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL add_t1 obs=%h exp=%h", w_obs, exp_v);
      end
      step();
      exp_v = pack(0, 8'h00, 8'h01, 0, 1, 0, 0, 0, 0, 0, 1);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL add_t2 obs=%h exp=%h", w_obs, exp_v);
      end
      step();
      exp_v = pack(0, 8'h01, 8'h00, 0, 0, 1, 0, 0, 1, 0, 1);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL add_t3 obs=%h exp=%h", w_obs, exp_v);
      end
      step();
      exp_v = pack(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL b2b_t0 obs=%h exp=%h", w_obs, exp_v);
      end
      step();
      Run = 1'b0;
      #1;
      exp_v = pack(0, 8'h40, 8'h02, 0, 0, 0, 0, 0, 1, 0, 1);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL b2b_mv_t1 obs=%h exp=%h", w_obs, exp_v);
      end
      step();
   endtask

   task automatic test_illegal();
      Run = 1'b1; DIN = 9'b111_000_000;
      step();
      Run = 1'b0;
      #1;
      exp_v = pack(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL illegal_t1 obs=%h exp=%h", w_obs, exp_v);
      end
      step();
      exp_v = pack(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL illegal_after obs=%h exp=%h", w_obs, exp_v);
      end
   endtask

   task automatic test_reset_mid();
      Run = 1'b1; DIN = 9'b010_011_101;
      step();
      Run = 1'b0;
      step();
      exp_v = pack(0, 8'h00, 8'h20, 0, 1, 0, 0, 0, 0, 0, 1);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL mid_t2 obs=%h exp=%h", w_obs, exp_v);
      end
      Resetn = 1'b0;
      #1;
      exp_v = pack(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL mid_reset_now obs=%h exp=%h", w_obs, exp_v);
      end
      step();
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL mid_reset_held obs=%h exp=%h", w_obs, exp_v);
      end
      Resetn = 1'b1;
      #1;
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL mid_release obs=%h exp=%h", w_obs, exp_v);
      end
      step();
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL mid_idle obs=%h exp=%h", w_obs, exp_v);
      end
      // Resumes normal operation from T0 with a fresh instruction.
      Run = 1'b1; DIN = 9'b001_000_000;
      step();
      Run = 1'b0;
      #1;
      exp_v = pack(0, 8'h01, 8'h00, 0, 0, 0, 1, 0, 1, 0, 1);
      checks++;
      if (w_obs !== exp_v) begin
         errors++;
         $display("FAIL mid_resume obs=%h exp=%h", w_obs, exp_v);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_mvi();
      test_mv();
      test_sub();
      test_back_to_back();
      test_illegal();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/proc_ctrl.md
PROC_CTRL -- requirements
Module: proc_ctrl

Interface
REQ-001 SHALL have port Clock, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port Resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Run, input, 1, start request; sampled only in state T0.
REQ-004 SHALL have port DIN, input, 9, instruction word in T0, immediate data word in T1 of mvi.
REQ-005 SHALL have port IRin, output, 1, instruction-register load strobe to datapath.
REQ-006 SHALL have port Rin, output, 8, one-hot register-file write enables R0..R7.
REQ-007 SHALL have port Rout, output, 8, one-hot register-file bus drive enables R0..R7.
REQ-008 SHALL have port Ain, output, 1, load enable for adder operand register A.
REQ-009 SHALL have port Gin, output, 1, load enable for adder result register G.
REQ-010 SHALL have port Gout, output, 1, G drives bus.
REQ-011 SHALL have port DINout, output, 1, DIN drives bus.
REQ-012 SHALL have port AddSub, output, 1, adder/subtractor mode, driven to the 9-bit add/sub unit carry-in/invert control; 0 = A+B, 1 = A-B.
REQ-013 SHALL have port Done, output, 1, one-cycle instruction-complete pulse.
REQ-014 SHALL have port Err, output, 1, one-cycle pulse coincident with Done for an unsupported opcode.
REQ-015 SHALL have port Busy, output, 1, high in any state other than T0.

Function
REQ-016 SHALL hold an internal 9-bit IR, format III XXX YYY (III = IR[8:6] opcode, XXX = IR[5:3] dest, YYY = IR[2:0] source).
REQ-017 SHALL implement a 4-state FSM T0, T1, T2, T3; all control outputs combinational from state and IR, except IRin, which also depends on Run.
REQ-018 T0: IRin = Run; on an edge with Run=1, IR <= DIN and next state T1; Run=0 holds T0 with IR unchanged.
REQ-019 T1, opcode 000 (mv Rx,Ry): Rout[YYY]=1, Rin[XXX]=1, Done=1; next T0.
REQ-020 T1, opcode 001 (mvi Rx,#D): DINout=1, Rin[XXX]=1, Done=1; next T0.
REQ-021 T1, opcode 010 (add) or 011 (sub): Rout[XXX]=1, Ain=1; next T2.
REQ-022 T1, opcode 1xx: Done=1, Err=1, no Rin/Rout/Ain/Gin asserted; next T0.
REQ-023 T2: Rout[YYY]=1, Gin=1, AddSub = IR[6] (sub=1, add=0); next T3.
REQ-024 T3: Gout=1, Rin[XXX]=1, Done=1; next T0.
REQ-025 AddSub SHALL be 0 in every state other than T2.
REQ-026 At most one Rout bit and at most one bus source (Rout, Gout, DINout) SHALL be active in any cycle.
REQ-027 Latency: mv/mvi/illegal = 2 cycles from Run edge to Done inclusive of T0; add/sub = 4 cycles.
REQ-028 Run SHALL be ignored in T1..T3; a new instruction is accepted only in T0, so Run held high back-to-back issues the next instruction in the cycle after Done.
REQ-029 X = Y (e.g. add R2,R2; mv R3,R3) SHALL be legal and sequenced identically.
REQ-030 Overflow/carry of the add/sub unit SHALL NOT affect sequencing.

Reset
REQ-031 Resetn=0 SHALL immediately, without clock, force state T0 and IR = 9'h000.
REQ-032 While Resetn=0, all outputs SHALL be 0, including IRin regardless of Run.
REQ-033 Reset asserted mid-instruction (T1..T3) SHALL abort it with no further Rin/Gin pulses; after release, operation resumes in T0.

Verification
REQ-034 Reset, Run=0 -> all outputs 0, Busy=0; release with Run=0 -> remain T0, outputs 0.
REQ-035 Run=1, DIN=9'b001_011_000 (mvi R3), then DIN=9'h05A in T1 -> T1 shows DINout=1, Rin=8'h08, Done=1; next cycle Busy=0.
REQ-036 DIN=9'b011_001_010 (sub R1,R2) -> T1 Rout=8'h02, Ain=1; T2 Rout=8'h04, Gin=1, AddSub=1; T3 Gout=1, Rin=8'h02, Done=1.
REQ-037 DIN=9'b010_000_000 (add R0,R0) then Run held high -> add sequence with AddSub=0 in T2, next IR loaded in the cycle after T3.
REQ-038 DIN=9'b111_000_000 -> T1 Done=1, Err=1, Rin=Rout=8'h00; back to T0.
REQ-039 Resetn pulsed low during T2 of add -> outputs 0 at once, Gin never asserted, FSM in T0 after release.
